ahb_blockram_if: RTL

AHB-Lite slave front-end for the on-chip 32-bit block RAM. It sits between the Cortex-M0 AHB-Lite bus and the RAM's write port (registered address, byte enables, data) and read port (address, registered data). It converts pipelined AHB address/data phases into single-cycle RAM accesses with zero wait states. It forwards a write's data to an immediately following read of the same word, so that read does not return stale data.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_blockram_if_if.sv | 35 +++
 rtl/ahb_blockram_if.sv | 91 +++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-lane decode used by AHB slaves
// that front 32-bit memories.
package ahb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] BYTE = 3'd0;
  localparam logic [2:0] HALF = 3'd1;
  localparam logic [2:0] WORD = 3'd2;

  // Sizes above WORD fall into the default branch and enable all four lanes.
  function automatic logic [3:0] byte_lanes(input logic [2:0] hsize,
                                            input logic [1:0] addr_lo);
    logic [3:0] lanes;
    case (hsize)
      BYTE:    lanes = 4'b0001 << addr_lo;
      HALF:    lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_blockram_if_if.sv
// AHB-Lite slave bus plus block-RAM read/write ports, bundled for the
// ahb_blockram_if front-end.
interface ahb_blockram_if_if #(
  parameter int ADDR_WIDTH = 12
) ();

  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic                  HWRITE;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [31:0]           HRDATA;
  logic [ADDR_WIDTH-1:0] BRAM_WRADDR;
  logic [31:0]           BRAM_WDATA;
  logic [3:0]            BRAM_WE;
  logic [ADDR_WIDTH-1:0] BRAM_RDADDR;
  logic [31:0]           BRAM_RDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, BRAM_RDATA,
    output HREADYOUT, HRESP, HRDATA,
    output BRAM_WRADDR, BRAM_WDATA, BRAM_WE, BRAM_RDADDR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, BRAM_RDATA,
    input  HREADYOUT, HRESP, HRDATA,
    input  BRAM_WRADDR, BRAM_WDATA, BRAM_WE, BRAM_RDADDR
  );

endinterface

// File: rtl/ahb_blockram_if.sv
// Zero-wait-state AHB-Lite slave for a 32-bit block RAM with registered read
// data; forwards write data into a read of the same word in the next cycle.
module ahb_blockram_if
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_blockram_if_if.slave  bus
);

  logic                  wr_pend_q, wr_pend_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  fwd_hit_q, fwd_hit_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]            wr_be_q,   wr_be_d;
  logic [3:0]            fwd_be_q,  fwd_be_d;
  logic [31:0]           fwd_data_q, fwd_data_d;

  logic                  accept;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  fwd_match;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic [3:0]            lanes;
  logic                  unused_bits;

  // Handshake: an address phase is taken when HSEL & HTRANS[1] & HREADY are
  // all high; HREADYOUT is tied high so every data phase completes in one cycle.
  assign haddr_word  = bus.HADDR[ADDR_WIDTH+1:2];
  assign unused_bits = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

  always_comb begin
    accept    = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    wr_accept = accept & bus.HWRITE;
    rd_accept = accept & ~bus.HWRITE;
    lanes     = byte_lanes(bus.HSIZE, bus.HADDR[1:0]);
    fwd_match = rd_accept & wr_pend_q & (haddr_word == wr_addr_q);
  end

  always_comb begin
    wr_pend_d  = wr_accept;
    wr_addr_d  = wr_accept ? haddr_word : wr_addr_q;
    wr_be_d    = wr_accept ? lanes : wr_be_q;
    rd_pend_d  = rd_accept;
    fwd_hit_d  = fwd_match;
    fwd_be_d   = fwd_match ? wr_be_q : fwd_be_q;
    fwd_data_d = fwd_match ? bus.HWDATA : fwd_data_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      fwd_hit_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_be_q    <= 4'b0;
      fwd_be_q   <= 4'b0;
      fwd_data_q <= 32'h0;
    end else begin
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      fwd_hit_q  <= fwd_hit_d;
      wr_addr_q  <= wr_addr_d;
      wr_be_q    <= wr_be_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign bus.HREADYOUT   = 1'b1;
  assign bus.HRESP       = 1'b0;
  assign bus.BRAM_RDADDR = haddr_word;
  assign bus.BRAM_WRADDR = wr_addr_q;
  assign bus.BRAM_WDATA  = bus.HWDATA;
  assign bus.BRAM_WE     = wr_pend_q ? wr_be_q : 4'b0;

  // The RAM read the old word while the preceding write landed; patch the
  // forwarded lanes over it.
  always_comb begin
    bus.HRDATA = 32'h0;
    if (rd_pend_q) begin
      for (int i = 0; i < 4; i++) begin
        bus.HRDATA[8*i +: 8] = (fwd_hit_q && fwd_be_q[i]) ? fwd_data_q[8*i +: 8]
                                                          : bus.BRAM_RDATA[8*i +: 8];
      end
    end
  end

endmodule
